booth_seq_ctrl: RTL and testbench



---
 rtl/booth_pkg.sv | 22 ++
 rtl/booth_seq_ctrl_step.sv | 34 +++
 rtl/booth_seq_ctrl.sv | 107 ++++++++++
 tb/tb_booth_seq_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants for the sequential Booth multiplier controller.
// BOOTH_SIGNED_EN selects two's-complement operands (default: unsigned).
package booth_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;

   // Unsigned operands need one extra bit so the MSB never reads as a sign.
   function automatic int ext_w(input int w);
`ifdef BOOTH_SIGNED_EN
      return w;
`else
      return w + 1;
`endif
   endfunction

endpackage

// File: rtl/booth_seq_ctrl_step.sv
// One radix-2 Booth step: add/sub of M into A, then arithmetic shift
// of {A,Q,q_1} right by one.
module booth_step
   import booth_pkg::*;
#(
   parameter int EW = 5
) (
   input  logic [EW:0]   a,
   input  logic [EW-1:0] q,
   input  logic          q_1,
   input  logic [EW:0]   m,
   output logic [EW:0]   a_n,
   output logic [EW-1:0] q_n,
   output logic          q_1_n
);

   logic [1:0]  op;
   logic [EW:0] sum;

   assign op = {q[0], q_1};

   always_comb begin
      sum = a;
      case (op)
         OP_ADD:  sum = a + m;
         OP_SUB:  sum = a - m;
         default: sum = a;
      endcase
      a_n   = {sum[EW], sum[EW:1]};
      q_n   = {sum[0], q[EW-1:1]};
      q_1_n = q[0];
   end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiply controller, one step per clock.
// Define BOOTH_SIGNED_EN for two's-complement operands and product.
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic               busy
);

   localparam int EW = ext_w(WIDTH);

   logic [1:0]       state;
   logic [EW:0]      a_r;
   logic [EW:0]      m_r;
   logic [EW-1:0]    q_r;
   logic             q_1_r;
   logic [CNT_W-1:0] cnt;

   logic [EW:0]      a_n;
   logic [EW-1:0]    q_n;
   logic             q_1_n;
   logic [EW:0]      m_ld;
   logic [EW-1:0]    q_ld;

   assign in_ready = (state == IDLE) & ena;
   assign busy     = (state == ITER) | (state == DONE);

   always_comb begin
`ifdef BOOTH_SIGNED_EN
      m_ld = (EW+1)'($signed(in_a));
      q_ld = EW'($signed(in_b));
`else
      m_ld = (EW+1)'(in_a);
      q_ld = EW'(in_b);
`endif
   end

   booth_step #(
      .EW (EW)
   ) u_step (
      .a     (a_r),
      .q     (q_r),
      .q_1   (q_1_r),
      .m     (m_r),
      .a_n   (a_n),
      .q_n   (q_n),
      .q_1_n (q_1_n)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_r       <= '0;
         m_r       <= '0;
         q_r       <= '0;
         q_1_r     <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_prod  <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  m_r   <= m_ld;
                  q_r   <= q_ld;
                  a_r   <= '0;
                  q_1_r <= 1'b0;
                  cnt   <= CNT_W'(EW);
                  state <= ITER;
               end
            end
            ITER: begin
               a_r   <= a_n;
               q_r   <= q_n;
               q_1_r <= q_1_n;
               cnt   <= cnt - CNT_W'(1);
               // Last step: capture the product straight from the step outputs.
               if (cnt == CNT_W'(1)) begin
                  out_prod  <= (2*WIDTH)'({a_n, q_n});
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed-vector bench for booth_seq_ctrl.
// Signed vectors are used when BOOTH_SIGNED_EN is defined.
module tb_booth_seq_ctrl;
   import booth_pkg::*;

   localparam int W  = 4;
   localparam int EW = ext_w(W);

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [2*W-1:0] out_prod;
   logic         busy;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   booth_seq_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp_p,
                         input int stall, input int hold);
      int n;
      bit stable;
      logic [2*W-1:0] p0;
      wait_ready(tag);
      out_ready = (hold == 0);
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_a = ~a;
      in_b = ~b;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      n = 1;
      while (!out_valid && n < 60) begin
         if (stall > 0 && n == 2) ena = 1'b0;
         if (stall > 0 && n == 2 + stall) ena = 1'b1;
         @(negedge clk);
         n++;
      end
      ena = 1'b1;
      check({tag, "_lat"}, 32'(n), 32'(EW + 1 + stall));
      check({tag, "_prod"}, 32'(out_prod), 32'(exp_p));
      if (hold > 0) begin
         p0 = out_prod;
         stable = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            if (!out_valid || out_prod !== p0 || in_ready) stable = 1'b0;
         end
         check({tag, "_stable"}, 32'(stable), 32'd1);
         ena = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         check({tag, "_ena_hold"}, 32'(out_valid), 32'd1);
         ena = 1'b1;
      end
      @(negedge clk);
      check({tag, "_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
      check({tag, "_keep"}, 32'(out_prod), 32'(exp_p));
   endtask

   initial begin
      bit quiet;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rdy_ena0", 32'(in_ready), 32'd0);
      check("rst_ovalid", 32'(out_valid), 32'd0);
      check("rst_prod", 32'(out_prod), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      ena = 1'b1;
      #1;
      check("rst_rdy_ena1", 32'(in_ready), 32'd1);

      run_op("m3x5", 4'd3, 4'd5, 8'h0F, 0, 0);
`ifdef BOOTH_SIGNED_EN
      run_op("s_m8m8", 4'h8, 4'h8, 8'h40, 0, 0);
      run_op("s_m8x7", 4'h8, 4'h7, 8'hC8, 0, 0);
      run_op("s_m1x1", 4'hF, 4'h1, 8'hFF, 0, 0);
`else
      run_op("u15x15", 4'hF, 4'hF, 8'hE1, 0, 0);
      run_op("u12x10", 4'hC, 4'hA, 8'h78, 0, 0);
`endif
      run_op("m0x9", 4'd0, 4'd9, 8'h00, 0, 0);
      run_op("bp6x7", 4'd6, 4'd7, 8'h2A, 0, 10);
      run_op("st4x5", 4'd4, 4'd5, 8'h14, 3, 0);

      // Reset mid-ITER discards the partial product.
      wait_ready("rst_op");
      in_a = 4'd7;
      in_b = 4'd3;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_ovalid", 32'(out_valid), 32'd0);
      check("arst_prod", 32'(out_prod), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (out_valid || !in_ready) quiet = 1'b0;
      end
      check("arst_quiet", 32'(quiet), 32'd1);
      run_op("m2x3", 4'd2, 4'd3, 8'h06, 0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
